// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and the control unit it feeds.
// Holds the fetch FSM encoding, the default boot address and the opcode field position.
package fetch_pkg;

  localparam int unsigned RESET_PC_DEFAULT = 0;

  // Opcode field inside an instruction byte; the control unit decodes these bits.
  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory and presents
// one instruction at a time to the decoder, honouring stall and branch redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = 8,
  parameter int                  INST_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic [PC_WIDTH-1:0]   pc_out
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [PC_WIDTH-1:0]   r_addr_q;
  logic [PC_WIDTH-1:0]   w_addr_next;
  logic [PC_WIDTH-1:0]   r_tgt_q;
  logic [PC_WIDTH-1:0]   w_tgt_next;
  logic [PC_WIDTH-1:0]   r_pc_out;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [INST_WIDTH-1:0] r_inst;
  logic [INST_WIDTH-1:0] w_inst_next;
  logic                  r_inst_valid;
  logic                  w_valid_next;
  logic                  r_imem_req;
  logic                  w_consume;

  assign w_consume = r_inst_valid & ~stall;

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr_q;
    w_tgt_next   = r_tgt_q;
    w_pc_next    = r_pc_out;
    w_inst_next  = r_inst;
    w_valid_next = r_inst_valid;

    unique case (r_state)
      BOOT: begin
        if (redirect) begin
          w_addr_next = redirect_pc;
        end
        w_state_next = REQ;
      end

      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returned byte belongs to the wrong path; refetch from the target.
            w_addr_next = redirect_pc;
          end else begin
            w_inst_next  = imem_rdata;
            w_pc_next    = r_addr_q;
            w_valid_next = 1'b1;
            w_addr_next  = r_addr_q + 1'b1;
            w_state_next = DRAIN;
          end
        end else if (redirect) begin
          // The read cannot be withdrawn, so park the target until it completes.
          w_tgt_next   = redirect_pc;
          w_state_next = FLUSH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          w_addr_next  = redirect_pc;
          w_state_next = REQ;
        end else if (!r_inst_valid || w_consume) begin
          w_valid_next = 1'b0;
          w_state_next = REQ;
        end
      end

      FLUSH: begin
        if (imem_ack) begin
          w_addr_next  = redirect ? redirect_pc : r_tgt_q;
          w_state_next = REQ;
        end else if (redirect) begin
          w_tgt_next = redirect_pc;
        end
      end
    endcase

    if (redirect) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BOOT;
      r_addr_q     <= RESET_PC;
      r_tgt_q      <= RESET_PC;
      r_pc_out     <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_imem_req   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr_q     <= w_addr_next;
      r_tgt_q      <= w_tgt_next;
      r_pc_out     <= w_pc_next;
      r_inst       <= w_inst_next;
      r_inst_valid <= w_valid_next;
      r_imem_req   <= (w_state_next == REQ) || (w_state_next == FLUSH);
    end
  end

  // addr_q only moves on an ack or outside a request, so it doubles as the bus address.
  assign imem_req   = r_imem_req;
  assign imem_addr  = r_addr_q;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc_out     = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by a randomized run,
// with a memory responder and a program-order model of which PC the decoder should see next.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [7:0] inst;
  logic       inst_valid;
  logic [7:0] pc_out;

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n_consumed = 0;
  logic [7:0] mem [256];
  int         lat_fixed;
  int         wait_left;
  logic       prev_req;
  logic       prev_ack;
  logic       prev_redirect;
  logic [7:0] prev_addr;
  logic [7:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc        = 8'h00;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    prev_redirect = 1'b0;
    prev_addr     = 8'h00;
    wait_left     = 0;
  endtask

  // Called at a falling edge: checks the bus contract, answers memory, applies
  // decoder inputs, scores any consumed instruction, then advances one cycle.
  task automatic step(input logic s, input logic r, input logic [7:0] t);
    if (prev_req && !prev_ack) begin
      chk("req_held", imem_req, 1'b1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (prev_redirect) chk("redirect_kills_valid", inst_valid, 1'b0);

    if (imem_req === 1'b1) begin
      if (!prev_req || prev_ack) wait_left = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
      imem_ack   = (wait_left == 0);
      imem_rdata = mem[imem_addr];
      if (wait_left > 0) wait_left--;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
    end
    stall       = s;
    redirect    = r;
    redirect_pc = t;

    if (inst_valid === 1'b1 && !s) begin
      $display("consume pc=%02h inst=%02h expected_pc=%02h", pc_out, inst, exp_pc);
      chk("consume_pc", pc_out, exp_pc);
      chk("consume_inst", inst, mem[exp_pc]);
      exp_pc = exp_pc + 8'd1;
      n_consumed++;
    end
    if (r) exp_pc = t;

    prev_req      = imem_req;
    prev_ack      = imem_ack;
    prev_addr     = imem_addr;
    prev_redirect = r;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && inst_valid !== 1'b1; i++) step(1'b1, 1'b0, 8'h00);
    chk(tag, inst_valid, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    model_reset();
    lat_fixed = 0;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_inst", inst, 8'h00);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_pc", pc_out, 8'h00);

    // 1: zero-wait boot
    reset = 1'b0;
    chk("t1_boot_no_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t1_req_cycle2", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("t1_valid", inst_valid, 1'b1);
    chk("t1_inst", inst, mem[0]);
    chk("t1_pc", pc_out, 8'h00);
    chk("t1_drain_no_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t1_req_addr1", imem_req, 1'b1);
    chk("t1_addr1", imem_addr, 8'h01);

    // 2: ack delayed 3 cycles
    lat_fixed = 3;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    chk("t2_valid", inst_valid, 1'b1);
    chk("t2_pc", pc_out, 8'h01);

    // 3: stall for 4 cycles
    repeat (4) begin
      step(1'b1, 1'b0, 8'h00);
      chk("t3_valid_hold", inst_valid, 1'b1);
      chk("t3_pc_hold", pc_out, 8'h01);
      chk("t3_inst_hold", inst, mem[1]);
      chk("t3_no_req", imem_req, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("t3_next_addr", imem_addr, 8'h02);

    // 4: redirect one cycle before a delayed ack
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h40);
    chk("t4_flush_req", imem_req, 1'b1);
    chk("t4_flush_addr", imem_addr, 8'h02);
    chk("t4_flush_valid", inst_valid, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t4_target_addr", imem_addr, 8'h40);
    chk("t4_valid_low", inst_valid, 1'b0);
    wait_valid("t4_wait_valid");
    chk("t4_pc", pc_out, 8'h40);
    chk("t4_inst", inst, mem[8'h40]);
    step(1'b0, 1'b0, 8'h00);

    // 5: redirect with ack, then a second redirect inside FLUSH
    lat_fixed = 0;
    step(1'b0, 1'b1, 8'h80);
    chk("t5_req", imem_req, 1'b1);
    chk("t5_addr80", imem_addr, 8'h80);
    chk("t5_valid_low", inst_valid, 1'b0);
    lat_fixed = 2;
    step(1'b0, 1'b1, 8'h90);
    step(1'b0, 1'b1, 8'hA0);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_last_target", imem_addr, 8'hA0);
    wait_valid("t5_wait_valid");
    chk("t5_pc", pc_out, 8'hA0);

    // 6: wrap from 8'hFF
    lat_fixed = 0;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_pc_ff", pc_out, 8'hFF);
    chk("t6_valid", inst_valid, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_wrap_addr", imem_addr, 8'h00);

    // 7: asynchronous reset with a request outstanding
    chk("t7_req_before", imem_req, 1'b1);
    imem_ack = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    reset    = 1'b1;
    #1;
    chk("t7_req", imem_req, 1'b0);
    chk("t7_addr", imem_addr, 8'h00);
    chk("t7_inst", inst, 8'h00);
    chk("t7_valid", inst_valid, 1'b0);
    chk("t7_pc", pc_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized traffic against the program-order model
    lat_fixed = -1;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
    end
    chk("liveness", 32'(n_consumed > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
